phase_accumulator: RTL and testbench

- Downstream consumer of the vibrato stage; forms the per-operator phase increment and accumulates operator phase for the NCO.
- Combines fnum, the vib_val offset, block, and the multiplier into an increment, then adds it to a per-operator phase accumulator held in on-chip RAM.
- Time-multiplexed over all operators; one operator slot per enabled cycle.
- Output phase feeds the sine/waveform lookup stage.

---
 rtl/opl2_pkg.sv | 21 ++
 rtl/calc_phase_inc.sv | 91 +++++++++
 rtl/phase_accumulator.sv | 115 +++++++++++
 tb/tb_phase_accumulator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl2_pkg.sv
// Shared OPL2 constants, the operator multiplier table and the phase-accumulator FSM states.
package opl2_pkg;
    localparam int NUM_OPERATORS   = 18;
    localparam int PHASE_ACC_WIDTH = 20;
    localparam int REG_FNUM_WIDTH  = 10;
    localparam int REG_BLOCK_WIDTH = 3;
    localparam int REG_MULT_WIDTH  = 4;
    localparam int VIB_VAL_WIDTH   = 3;
    localparam int OP_NUM_WIDTH    = 5;
    localparam int PHASE_OUT_WIDTH = 10;
    localparam int INC_BASE_WIDTH  = 17;
    localparam int MULT2_WIDTH     = 5;

    // Twice the real frequency multiple, so the x0.5 code stays an integer.
    localparam logic [MULT2_WIDTH-1:0] MULT2 [2**REG_MULT_WIDTH] = '{
        5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
        5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30
    };

    typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/calc_phase_inc.sv
// Phase-increment pipeline: vibrato add (p1), block shift (p2), multiply (p3).
// Build option PHASE_ACC_VIB_CLAMP_EN clamps a negative fnum+vib_val to 0 instead of wrapping.
module calc_phase_inc
    import opl2_pkg::*;
(
    input  logic                              clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    input  logic [OP_NUM_WIDTH-1:0]           i_op,
    input  logic [REG_FNUM_WIDTH-1:0]         i_fnum,
    input  logic [REG_BLOCK_WIDTH-1:0]        i_block,
    input  logic [REG_MULT_WIDTH-1:0]         i_mult,
    input  logic                              i_vib,
    input  logic signed [VIB_VAL_WIDTH-1:0]   i_vib_val,
    input  logic                              i_key_on,
    output logic                              o_valid,
    output logic [OP_NUM_WIDTH-1:0]           o_op,
    output logic [PHASE_ACC_WIDTH-1:0]        o_inc,
    output logic                              o_key_on
);
    localparam int SUM_W   = REG_FNUM_WIDTH + 2;
    localparam int F_W     = REG_FNUM_WIDTH + 1;
    localparam int SHIFT_W = F_W + (2**REG_BLOCK_WIDTH) - 1;
    localparam int PROD_W  = PHASE_ACC_WIDTH + 1;

    function automatic logic [F_W-1:0] vib_add(
        input logic [REG_FNUM_WIDTH-1:0]       fnum,
        input logic                            vib,
        input logic signed [VIB_VAL_WIDTH-1:0] vib_val
    );
        logic signed [SUM_W-1:0] ofs;
        logic signed [SUM_W-1:0] sum;
        ofs = vib ? {{(SUM_W-VIB_VAL_WIDTH){vib_val[VIB_VAL_WIDTH-1]}}, vib_val} : '0;
        sum = $signed({2'b00, fnum}) + ofs;
`ifdef PHASE_ACC_VIB_CLAMP_EN
        return (sum < 0) ? '0 : F_W'(sum);
`else
        return {1'b0, REG_FNUM_WIDTH'(sum)};
`endif
    endfunction

    logic                        r_vld_p1, r_vld_p2, r_vld_p3;
    logic [OP_NUM_WIDTH-1:0]     r_op_p1, r_op_p2, r_op_p3;
    logic                        r_key_p1, r_key_p2, r_key_p3;
    logic [F_W-1:0]              r_f_p1;
    logic [REG_BLOCK_WIDTH-1:0]  r_block_p1;
    logic [REG_MULT_WIDTH-1:0]   r_mult_p1, r_mult_p2;
    logic [INC_BASE_WIDTH-1:0]   r_inc_base_p2;
    logic [PHASE_ACC_WIDTH-1:0]  r_inc_p3;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else begin
            r_vld_p1 <= i_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // p1: vibrato add
    always_ff @(posedge clk) begin
        r_op_p1    <= i_op;
        r_key_p1   <= i_key_on;
        r_f_p1     <= vib_add(i_fnum, i_vib, i_vib_val);
        r_block_p1 <= i_block;
        r_mult_p1  <= i_mult;
    end

    // p2: octave shift, halved
    always_ff @(posedge clk) begin
        r_op_p2       <= r_op_p1;
        r_key_p2      <= r_key_p1;
        r_mult_p2     <= r_mult_p1;
        r_inc_base_p2 <= INC_BASE_WIDTH'((SHIFT_W'(r_f_p1) << r_block_p1) >> 1);
    end

    // p3: multiplier, halved to undo the doubled table
    always_ff @(posedge clk) begin
        r_op_p3  <= r_op_p2;
        r_key_p3 <= r_key_p2;
        r_inc_p3 <= PHASE_ACC_WIDTH'((PROD_W'(r_inc_base_p2) * PROD_W'(MULT2[r_mult_p2])) >> 1);
    end

    assign o_valid  = r_vld_p3;
    assign o_op     = r_op_p3;
    assign o_inc    = r_inc_p3;
    assign o_key_on = r_key_p3;
endmodule

// File: rtl/phase_accumulator.sv
// Per-operator phase accumulator: increment pipeline followed by a read-modify-write of the phase RAM.
// Build option PHASE_ACC_VIB_CLAMP_EN selects clamping of negative fnum+vib_val (see calc_phase_inc).
module phase_accumulator
    import opl2_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             op_valid,
    input  logic [OP_NUM_WIDTH-1:0]          op_num,
    input  logic [REG_FNUM_WIDTH-1:0]        fnum,
    input  logic [REG_BLOCK_WIDTH-1:0]       block,
    input  logic [REG_MULT_WIDTH-1:0]        mult,
    input  logic                             vib,
    input  logic signed [VIB_VAL_WIDTH-1:0]  vib_val,
    input  logic                             key_on,
    output logic                             ready,
    output logic                             phase_valid,
    output logic [OP_NUM_WIDTH-1:0]          phase_op,
    output logic [PHASE_OUT_WIDTH-1:0]       phase
);
    localparam logic [OP_NUM_WIDTH-1:0] LAST_OP = OP_NUM_WIDTH'(NUM_OPERATORS - 1);

    state_t                      r_state, w_state_nxt;
    logic [OP_NUM_WIDTH-1:0]     r_clr_cnt, w_clr_cnt_nxt;
    logic [PHASE_ACC_WIDTH-1:0]  r_acc [NUM_OPERATORS];
    logic                        r_key_prev [NUM_OPERATORS];

    logic                        w_in_valid;
    logic                        w_vld_p3;
    logic [OP_NUM_WIDTH-1:0]     w_op_p3;
    logic [PHASE_ACC_WIDTH-1:0]  w_inc_p3;
    logic                        w_key_p3;
    logic                        w_slot_ok;
    logic [OP_NUM_WIDTH-1:0]     w_idx;
    logic                        w_key_rise;
    logic [PHASE_ACC_WIDTH-1:0]  w_acc_new;

    assign ready      = (r_state == RUN);
    assign w_in_valid = op_valid && ready;

    calc_phase_inc u_calc_phase_inc (
        .clk       (clk),
        .i_rst     (reset),
        .i_valid   (w_in_valid),
        .i_op      (op_num),
        .i_fnum    (fnum),
        .i_block   (block),
        .i_mult    (mult),
        .i_vib     (vib),
        .i_vib_val (vib_val),
        .i_key_on  (key_on),
        .o_valid   (w_vld_p3),
        .o_op      (w_op_p3),
        .o_inc     (w_inc_p3),
        .o_key_on  (w_key_p3)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == LAST_OP) begin
                    w_state_nxt   = RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + OP_NUM_WIDTH'(1);
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // p4: the RAM is read combinationally and written on the same edge that registers the
    // result, so a following slot for the same operator always sees the freshest value.
    assign w_slot_ok  = (w_op_p3 <= LAST_OP);
    assign w_idx      = w_slot_ok ? w_op_p3 : '0;
    assign w_key_rise = w_key_p3 && !r_key_prev[w_idx];
    assign w_acc_new  = w_key_rise ? '0 : (r_acc[w_idx] + w_inc_p3);

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_acc[r_clr_cnt]      <= '0;
            r_key_prev[r_clr_cnt] <= 1'b0;
        end else if (!reset && w_vld_p3 && w_slot_ok) begin
            r_acc[w_idx]      <= w_acc_new;
            r_key_prev[w_idx] <= w_key_p3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_valid <= 1'b0;
            phase_op    <= '0;
            phase       <= '0;
        end else begin
            phase_valid <= w_vld_p3;
            if (w_vld_p3) begin
                phase_op <= w_op_p3;
                phase    <= w_slot_ok ? PHASE_OUT_WIDTH'(w_acc_new >> (PHASE_ACC_WIDTH - PHASE_OUT_WIDTH)) : '0;
            end
        end
    end
endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: directed scenarios plus randomized traffic
// against a behavioural per-operator phase model. Honours PHASE_ACC_VIB_CLAMP_EN.
module tb_phase_accumulator;
    typedef struct packed {
        int         cyc;
        logic [4:0] op;
        logic [9:0] ph;
    } txn_t;

    localparam int MULT_X2 [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              op_valid = 1'b0;
    logic [4:0]        op_num = '0;
    logic [9:0]        fnum = '0;
    logic [2:0]        block = '0;
    logic [3:0]        mult = '0;
    logic              vib = 1'b0;
    logic signed [2:0] vib_val = '0;
    logic              key_on = 1'b0;
    logic              ready, phase_valid;
    logic [4:0]        phase_op;
    logic [9:0]        phase;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   m_acc [18];
    bit   m_key [18];
    bit   keys [32];
    txn_t exp_q [$];
    txn_t obs_q [$];

    phase_accumulator dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_num(op_num), .fnum(fnum),
        .block(block), .mult(mult), .vib(vib), .vib_val(vib_val), .key_on(key_on),
        .ready(ready), .phase_valid(phase_valid), .phase_op(phase_op), .phase(phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (phase_valid === 1'b1) obs_q.push_back('{cyc: cyc, op: phase_op, ph: phase});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1);
    end

    function automatic int model_inc(int fn, int blk, int ml, bit vb, int vv3);
        int vv;
        int f;
        int base;
        vv = (vv3 >= 4) ? vv3 - 8 : vv3;
        f  = fn + (vb ? vv : 0);
`ifdef PHASE_ACC_VIB_CLAMP_EN
        if (f < 0) f = 0;
`else
        f = f & 'h3FF;
`endif
        base = ((f * (1 << blk)) / 2) & 'h1FFFF;
        return (base * MULT_X2[ml]) / 2;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 18; i++) begin
            m_acc[i] = 0;
            m_key[i] = 1'b0;
        end
        for (int i = 0; i < 32; i++) keys[i] = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int op, input int fn, input int blk, input int ml,
                        input bit vb, input int vv, input bit key);
        int ph;
        ph = 0;
        if (op < 18) begin
            if (key && !m_key[op]) m_acc[op] = 0;
            else m_acc[op] = (m_acc[op] + model_inc(fn, blk, ml, vb, vv)) % (1 << 20);
            m_key[op] = key;
            ph = m_acc[op] / 1024;
        end
        exp_q.push_back('{cyc: cyc + 4, op: 5'(op), ph: 10'(ph)});
        op_valid = 1'b1;
        op_num = 5'(op); fnum = 10'(fn); block = 3'(blk); mult = 4'(ml);
        vib = vb; vib_val = 3'(vv); key_on = key;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        txn_t e, o;
        int want [$];
        reset = 1'b1;
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({ready, phase_valid, phase_op, phase} !== 17'd0)
            begin failed++; $display("FAIL reset_outputs: got %h, want 0", {ready, phase_valid, phase_op, phase}); end
        reset = 1'b0;
        model_clear();
        for (int k = 0; k <= 18; k++) begin
            tests++;
            if (ready !== (k == 18))
                begin failed++; $display("FAIL ready_after_%0d_cycles: got %b, want %b", k, ready, (k == 18)); end
            op_valid = (k < 18); op_num = 5'd2; fnum = 10'h3FF; block = 3'd7; mult = 4'd15; key_on = 1'b0;
            @(negedge clk);
        end
        idle(6);
        tests++;
        if (obs_q.size() != 0)
            begin failed++; $display("FAIL ignored_while_clearing: got %0d outputs, want 0", obs_q.size()); obs_q.delete(); end
        for (int op = 0; op < 18; op++) begin
            send(op, 0, 0, 0, 0, 0, 0);
            want.push_back(0);
        end
        idle(8);
        for (int k = 0; k < want.size(); k++) begin
            e = exp_q.pop_front();
            o = '{cyc: -1, op: 5'd0, ph: 10'd0};
            if (obs_q.size() > 0) o = obs_q.pop_front();
            tests++;
            if (o !== e || o.ph !== 10'(want[k])) begin failed++;
                $display("FAIL cleared_slot: got op=%0d phase=%0d cyc=%0d, want op=%0d phase=%0d cyc=%0d", o.op, o.ph, o.cyc, e.op, want[k], e.cyc); end
        end
    endtask

    task automatic test_step();
        txn_t e, o;
        int want [$];
        for (int v = 1; v <= 130; v++) begin
            send(0, 'h200, 5, 1, 0, 0, 0);
            want.push_back((8 * v) % 1024);
            idle(17);
        end
        for (int k = 0; k < want.size(); k++) begin
            e = exp_q.pop_front();
            o = '{cyc: -1, op: 5'd0, ph: 10'd0};
            if (obs_q.size() > 0) o = obs_q.pop_front();
            tests++;
            if (o !== e || o.ph !== 10'(want[k])) begin failed++;
                $display("FAIL step_visit_%0d: got op=%0d phase=%0d cyc=%0d, want op=%0d phase=%0d cyc=%0d", k + 1, o.op, o.ph, o.cyc, e.op, want[k], e.cyc); end
        end
        tests++;
        if (obs_q.size() != 0) begin failed++; $display("FAIL step_extra: got %0d outputs, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_mult_vib();
        txn_t e, o;
        int want [$];
        send(1, 'h200, 5, 0, 0, 0, 0);  want.push_back(4);
        send(2, 'h200, 5, 15, 0, 0, 0); want.push_back(120);
        send(1, 'h200, 5, 0, 0, 0, 0);  want.push_back(8);
        send(2, 'h200, 5, 15, 0, 0, 0); want.push_back(240);
        send(4, 1, 7, 1, 1, 6, 0);
`ifdef PHASE_ACC_VIB_CLAMP_EN
        want.push_back(0);
`else
        want.push_back(63);
`endif
        idle(8);
        for (int k = 0; k < want.size(); k++) begin
            e = exp_q.pop_front();
            o = '{cyc: -1, op: 5'd0, ph: 10'd0};
            if (obs_q.size() > 0) o = obs_q.pop_front();
            tests++;
            if (o !== e || o.ph !== 10'(want[k])) begin failed++;
                $display("FAIL mult_vib_%0d: got op=%0d phase=%0d cyc=%0d, want op=%0d phase=%0d cyc=%0d", k, o.op, o.ph, o.cyc, e.op, want[k], e.cyc); end
        end
    endtask

    task automatic test_back_to_back();
        txn_t e, o;
        int want [$];
        send(3, 'h200, 7, 1, 0, 0, 0); want.push_back(32);
        send(3, 'h200, 7, 1, 0, 0, 0); want.push_back(64);
        send(3, 'h200, 7, 1, 0, 0, 0); want.push_back(96);
        idle(1);
        send(3, 'h200, 7, 1, 0, 0, 0); want.push_back(128);
        idle(2);
        send(3, 'h200, 7, 1, 0, 0, 0); want.push_back(160);
        send(19, 'h200, 7, 1, 0, 0, 0); want.push_back(0);
        send(31, 'h3FF, 7, 15, 0, 0, 0); want.push_back(0);
        send(18, 'h200, 7, 1, 0, 0, 1); want.push_back(0);
        send(3, 'h200, 7, 1, 0, 0, 0); want.push_back(192);
        idle(8);
        for (int k = 0; k < want.size(); k++) begin
            e = exp_q.pop_front();
            o = '{cyc: -1, op: 5'd0, ph: 10'd0};
            if (obs_q.size() > 0) o = obs_q.pop_front();
            tests++;
            if (o !== e || o.ph !== 10'(want[k])) begin failed++;
                $display("FAIL back_to_back_%0d: got op=%0d phase=%0d cyc=%0d, want op=%0d phase=%0d cyc=%0d", k, o.op, o.ph, o.cyc, e.op, want[k], e.cyc); end
        end
    endtask

    task automatic test_key_on();
        txn_t e, o;
        int want [$];
        send(5, 'h200, 7, 1, 0, 0, 0); want.push_back(32);
        send(5, 'h200, 7, 1, 0, 0, 0); want.push_back(64);
        send(5, 'h200, 7, 1, 0, 0, 1); want.push_back(0);
        send(5, 'h200, 7, 1, 0, 0, 1); want.push_back(32);
        idle(3);
        send(5, 'h200, 7, 1, 0, 0, 1); want.push_back(64);
        send(5, 'h200, 7, 1, 0, 0, 0); want.push_back(96);
        send(5, 'h200, 7, 1, 0, 0, 1); want.push_back(0);
        idle(8);
        for (int k = 0; k < want.size(); k++) begin
            e = exp_q.pop_front();
            o = '{cyc: -1, op: 5'd0, ph: 10'd0};
            if (obs_q.size() > 0) o = obs_q.pop_front();
            tests++;
            if (o !== e || o.ph !== 10'(want[k])) begin failed++;
                $display("FAIL key_on_%0d: got op=%0d phase=%0d cyc=%0d, want op=%0d phase=%0d cyc=%0d", k, o.op, o.ph, o.cyc, e.op, want[k], e.cyc); end
        end
    endtask

    task automatic test_random();
        txn_t e, o;
        int op;
        int fn;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            op = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 23));
            if ($urandom_range(0, 5) == 0) keys[op] = !keys[op];
            fn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
            send(op, fn, $urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7), keys[op]);
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{cyc: -1, op: 5'd0, ph: 10'd0};
            if (obs_q.size() > 0) o = obs_q.pop_front();
            tests++;
            if (o !== e) begin failed++;
                $display("FAIL random: got op=%0d phase=%0d cyc=%0d, want op=%0d phase=%0d cyc=%0d", o.op, o.ph, o.cyc, e.op, e.ph, e.cyc); end
        end
        tests++;
        if (obs_q.size() != 0) begin failed++; $display("FAIL random_extra: got %0d outputs, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_midstream();
        txn_t e, o;
        int want [$];
        send(7, 'h200, 7, 1, 0, 0, 0);
        send(7, 'h200, 7, 1, 0, 0, 0);
        send(0, 'h200, 7, 1, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (ready !== 1'b0 || phase_valid !== 1'b0)
            begin failed++; $display("FAIL midreset_outputs: got ready=%b valid=%b, want 0 0", ready, phase_valid); end
        reset = 1'b0;
        model_clear();
        idle(17);
        tests++;
        if (ready !== 1'b0) begin failed++; $display("FAIL midreset_clearing: got ready=%b, want 0", ready); end
        idle(1);
        tests++;
        if (ready !== 1'b1) begin failed++; $display("FAIL midreset_ready: got ready=%b, want 1", ready); end
        tests++;
        if (obs_q.size() != 0)
            begin failed++; $display("FAIL midreset_discard: got %0d outputs, want 0", obs_q.size()); obs_q.delete(); end
        send(7, 'h200, 7, 1, 0, 0, 0); want.push_back(32);
        send(0, 'h200, 5, 1, 0, 0, 0); want.push_back(8);
        idle(8);
        for (int k = 0; k < want.size(); k++) begin
            e = exp_q.pop_front();
            o = '{cyc: -1, op: 5'd0, ph: 10'd0};
            if (obs_q.size() > 0) o = obs_q.pop_front();
            tests++;
            if (o !== e || o.ph !== 10'(want[k])) begin failed++;
                $display("FAIL midreset_restart_%0d: got op=%0d phase=%0d cyc=%0d, want op=%0d phase=%0d cyc=%0d", k, o.op, o.ph, o.cyc, e.op, want[k], e.cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_mult_vib();
        test_back_to_back();
        test_key_on();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
